// File: rtl/execute_forwarding_history.sv
// rtl/execute_forwarding_history.sv - execute-stage multi-entry writeback forwarding store with SPR forwarding register
module execute_forwarding_history #(
  parameter int DEPTH    = 4,
  parameter int DATA_W   = 32,
  parameter int DEST_W   = 5,
  parameter int RD_PORTS = 2,
  localparam int CNT_W   = $clog2(DEPTH + 1)
) (
  input  logic                         iCLOCK,
  input  logic                         inRESET,
  input  logic                         iRESET_SYNC,
  input  logic                         iFLUSH,
  input  logic                         iWB_GR_VALID,
  input  logic [DATA_W-1:0]            iWB_GR_DATA,
  input  logic [DEST_W-1:0]            iWB_GR_DEST,
  input  logic                         iWB_GR_DEST_SYSREG,
  input  logic [RD_PORTS*DEST_W-1:0]   iLK_DEST,
  input  logic [RD_PORTS-1:0]          iLK_SYSREG,
  output logic [RD_PORTS-1:0]          oLK_HIT,
  output logic [RD_PORTS*DATA_W-1:0]   oLK_DATA,
  output logic [CNT_W-1:0]             oFDR_GR_COUNT,
  input  logic                         iWB_SPR_VALID,
  input  logic [31:0]                  iWB_SPR_DATA,
  input  logic                         iWB_AUTO_SPR_VALID,
  input  logic [31:0]                  iWB_AUTO_SPR_DATA,
  input  logic [31:0]                  iCUUR_SPR_DATA,
  output logic                         oFDR_SPR_VALID,
  output logic [31:0]                  oFDR_SPR_DATA
);

  // History entries; index 0 always holds the youngest writeback.
  logic              ent_valid  [DEPTH];
  logic [DATA_W-1:0] ent_data   [DEPTH];
  logic [DEST_W-1:0] ent_dest   [DEPTH];
  logic              ent_sysreg [DEPTH];
  logic [CNT_W-1:0]  gr_count;

  logic              spr_valid;
  logic [31:0]       spr_data;

  // Age-ordered shift register: flush only drops validity, a write pushes a new youngest entry.
  always_ff @(posedge iCLOCK or negedge inRESET) begin
    if (!inRESET) begin
      for (int k = 0; k < DEPTH; k++) begin
        ent_valid[k]  <= 1'b0;
        ent_data[k]   <= '0;
        ent_dest[k]   <= '0;
        ent_sysreg[k] <= 1'b0;
      end
      gr_count <= '0;
    end else if (iRESET_SYNC) begin
      for (int k = 0; k < DEPTH; k++) begin
        ent_valid[k]  <= 1'b0;
        ent_data[k]   <= '0;
        ent_dest[k]   <= '0;
        ent_sysreg[k] <= 1'b0;
      end
      gr_count <= '0;
    end else if (iFLUSH) begin
      // Data fields are left stale; with valid cleared they can never match.
      for (int k = 0; k < DEPTH; k++) begin
        ent_valid[k] <= 1'b0;
      end
      gr_count <= '0;
    end else if (iWB_GR_VALID) begin
      for (int k = DEPTH - 1; k > 0; k--) begin
        ent_valid[k]  <= ent_valid[k-1];
        ent_data[k]   <= ent_data[k-1];
        ent_dest[k]   <= ent_dest[k-1];
        ent_sysreg[k] <= ent_sysreg[k-1];
      end
      ent_valid[0]  <= 1'b1;
      ent_data[0]   <= iWB_GR_DATA;
      ent_dest[0]   <= iWB_GR_DEST;
      ent_sysreg[0] <= iWB_GR_DEST_SYSREG;
      if (gr_count != CNT_W'(DEPTH)) begin
        gr_count <= gr_count + CNT_W'(1);
      end
    end
  end

  // Per-port lookup over registered entries; scanning oldest to youngest lets the youngest match win.
  always_comb begin
    oLK_HIT  = '0;
    oLK_DATA = '0;
    for (int p = 0; p < RD_PORTS; p++) begin
      for (int k = DEPTH - 1; k >= 0; k--) begin
        if (ent_valid[k] &&
            (ent_dest[k] == iLK_DEST[p*DEST_W +: DEST_W]) &&
            (ent_sysreg[k] == iLK_SYSREG[p])) begin
          oLK_HIT[p]                    = 1'b1;
          oLK_DATA[p*DATA_W +: DATA_W]  = ent_data[k];
        end
      end
    end
  end

  // SPR forwarding value: explicit writeback beats auto update, otherwise track the architectural value.
  always_ff @(posedge iCLOCK or negedge inRESET) begin
    if (!inRESET) begin
      spr_valid <= 1'b0;
      spr_data  <= '0;
    end else if (iRESET_SYNC) begin
      spr_valid <= 1'b0;
      spr_data  <= '0;
    end else if (iWB_SPR_VALID) begin
      spr_valid <= 1'b1;
      spr_data  <= iWB_SPR_DATA;
    end else if (iWB_AUTO_SPR_VALID) begin
      spr_valid <= 1'b1;
      spr_data  <= iWB_AUTO_SPR_DATA;
    end else begin
      spr_valid <= 1'b1;
      spr_data  <= iCUUR_SPR_DATA;
    end
  end

  assign oFDR_GR_COUNT  = gr_count;
  assign oFDR_SPR_VALID = spr_valid;
  assign oFDR_SPR_DATA  = spr_data;

endmodule

// File: tb/tb_execute_forwarding_history.sv
// tb/tb_execute_forwarding_history.sv - scoreboard bench for execute_forwarding_history
module tb_execute_forwarding_history;

  logic        iCLOCK = 1'b0;
  logic        inRESET;
  logic        iRESET_SYNC;
  logic        iFLUSH;
  logic        iWB_GR_VALID;
  logic [31:0] iWB_GR_DATA;
  logic [4:0]  iWB_GR_DEST;
  logic        iWB_GR_DEST_SYSREG;
  logic [9:0]  iLK_DEST;
  logic [1:0]  iLK_SYSREG;
  logic [1:0]  oLK_HIT;
  logic [63:0] oLK_DATA;
  logic [2:0]  oFDR_GR_COUNT;
  logic        iWB_SPR_VALID;
  logic [31:0] iWB_SPR_DATA;
  logic        iWB_AUTO_SPR_VALID;
  logic [31:0] iWB_AUTO_SPR_DATA;
  logic [31:0] iCUUR_SPR_DATA;
  logic        oFDR_SPR_VALID;
  logic [31:0] oFDR_SPR_DATA;

  execute_forwarding_history dut (
    .iCLOCK             (iCLOCK),
    .inRESET            (inRESET),
    .iRESET_SYNC        (iRESET_SYNC),
    .iFLUSH             (iFLUSH),
    .iWB_GR_VALID       (iWB_GR_VALID),
    .iWB_GR_DATA        (iWB_GR_DATA),
    .iWB_GR_DEST        (iWB_GR_DEST),
    .iWB_GR_DEST_SYSREG (iWB_GR_DEST_SYSREG),
    .iLK_DEST           (iLK_DEST),
    .iLK_SYSREG         (iLK_SYSREG),
    .oLK_HIT            (oLK_HIT),
    .oLK_DATA           (oLK_DATA),
    .oFDR_GR_COUNT      (oFDR_GR_COUNT),
    .iWB_SPR_VALID      (iWB_SPR_VALID),
    .iWB_SPR_DATA       (iWB_SPR_DATA),
    .iWB_AUTO_SPR_VALID (iWB_AUTO_SPR_VALID),
    .iWB_AUTO_SPR_DATA  (iWB_AUTO_SPR_DATA),
    .iCUUR_SPR_DATA     (iCUUR_SPR_DATA),
    .oFDR_SPR_VALID     (oFDR_SPR_VALID),
    .oFDR_SPR_DATA      (oFDR_SPR_DATA)
  );

  always #5 iCLOCK = ~iCLOCK;

  typedef struct packed {
    logic [1:0]  hit;
    logic [63:0] data;
    logic [2:0]  cnt;
    logic        chk_spr;
    logic        spr_v;
    logic [31:0] spr_d;
  } exp_t;

  exp_t  exp_q  [$];
  string name_q [$];
  int    vectors = 0;
  int    miscompares = 0;
  logic  probe = 1'b0;

  // Monitor: drains every pending expectation at the falling edge, or on an off-edge probe.
  initial begin
    exp_t  e;
    string n;
    forever begin
      @(negedge iCLOCK or posedge probe);
      while (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        n = name_q.pop_front();
        vectors++;
        if ((oLK_HIT !== e.hit) || (oLK_DATA !== e.data) || (oFDR_GR_COUNT !== e.cnt) ||
            (e.chk_spr && ((oFDR_SPR_VALID !== e.spr_v) || (oFDR_SPR_DATA !== e.spr_d)))) begin
          miscompares++;
          $display("FAIL %s: got hit=%b data=%h cnt=%0d spr=%b/%h, need hit=%b data=%h cnt=%0d spr=%b/%h (spr checked=%b)",
                   n, oLK_HIT, oLK_DATA, oFDR_GR_COUNT, oFDR_SPR_VALID, oFDR_SPR_DATA,
                   e.hit, e.data, e.cnt, e.spr_v, e.spr_d, e.chk_spr);
        end
      end
    end
  end

  task automatic step();
    @(posedge iCLOCK);
    #1;
  endtask

  task automatic wr(input logic v, input logic [4:0] d, input logic s, input logic [31:0] x);
    iWB_GR_VALID       = v;
    iWB_GR_DEST        = d;
    iWB_GR_DEST_SYSREG = s;
    iWB_GR_DATA        = x;
  endtask

  task automatic lk(input logic [4:0] d0, input logic s0, input logic [4:0] d1, input logic s1);
    iLK_DEST   = {d1, d0};
    iLK_SYSREG = {s1, s0};
  endtask

  task automatic expect_all(input string n, input logic [1:0] hit, input logic [31:0] d0,
                            input logic [31:0] d1, input logic [2:0] cnt, input logic chk,
                            input logic sv, input logic [31:0] sd);
    exp_t e;
    e.hit     = hit;
    e.data    = {d1, d0};
    e.cnt     = cnt;
    e.chk_spr = chk;
    e.spr_v   = sv;
    e.spr_d   = sd;
    exp_q.push_back(e);
    name_q.push_back(n);
  endtask

  task automatic expect_gr(input string n, input logic [1:0] hit, input logic [31:0] d0,
                           input logic [31:0] d1, input logic [2:0] cnt);
    expect_all(n, hit, d0, d1, cnt, 1'b0, 1'b0, 32'h0);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish, need completion");
    $fatal(1, "timeout");
  end

  initial begin
    inRESET = 1'b0; iRESET_SYNC = 1'b0; iFLUSH = 1'b0;
    wr(1'b0, 5'd0, 1'b0, 32'h0);
    lk(5'd0, 1'b0, 5'd0, 1'b0);
    iWB_SPR_VALID = 1'b0; iWB_SPR_DATA = '0;
    iWB_AUTO_SPR_VALID = 1'b0; iWB_AUTO_SPR_DATA = '0;
    iCUUR_SPR_DATA = '0;

    step();
    expect_all("reset_state", 2'b00, 32'h0, 32'h0, 3'd0, 1'b1, 1'b0, 32'h0);
    step();
    inRESET = 1'b1;

    // single write, visible one cycle later
    wr(1'b1, 5'd3, 1'b0, 32'hAAAA0001);
    lk(5'd3, 1'b0, 5'd3, 1'b0);
    expect_gr("write_cycle_miss", 2'b00, 32'h0, 32'h0, 3'd0);
    step();
    wr(1'b0, 5'd0, 1'b0, 32'h0);
    expect_gr("r3_hit", 2'b11, 32'hAAAA0001, 32'hAAAA0001, 3'd1);
    step();

    // duplicate destination: youngest wins, sysreg space separate
    wr(1'b1, 5'd7, 1'b0, 32'h11); step();
    wr(1'b1, 5'd7, 1'b0, 32'h22); step();
    wr(1'b0, 5'd0, 1'b0, 32'h0);
    lk(5'd7, 1'b0, 5'd7, 1'b1);
    expect_gr("r7_youngest_sys7_miss", 2'b01, 32'h22, 32'h0, 3'd3);
    step();
    lk(5'd3, 1'b0, 5'd7, 1'b0);
    expect_gr("r3_r7_both", 2'b11, 32'hAAAA0001, 32'h22, 3'd3);
    step();

    // overflow: r1..r5, r1 drops out, count saturates
    for (int i = 1; i <= 5; i++) begin
      wr(1'b1, 5'(i), 1'b0, 32'(i));
      step();
    end
    wr(1'b0, 5'd0, 1'b0, 32'h0);
    lk(5'd1, 1'b0, 5'd2, 1'b0);
    expect_gr("r1_dropped_r2_hit", 2'b10, 32'h0, 32'h2, 3'd4);
    step();
    lk(5'd5, 1'b0, 5'd3, 1'b0);
    expect_gr("r5_r3_hit", 2'b11, 32'h5, 32'h3, 3'd4);
    step();
    lk(5'd4, 1'b0, 5'd7, 1'b0);
    expect_gr("r4_hit_r7_gone", 2'b01, 32'h4, 32'h0, 3'd4);
    step();

    // GR 5 vs sysreg 5 never alias
    wr(1'b1, 5'd5, 1'b1, 32'h500); step();
    wr(1'b0, 5'd0, 1'b0, 32'h0);
    lk(5'd5, 1'b0, 5'd5, 1'b1);
    expect_gr("gr5_vs_sys5", 2'b11, 32'h5, 32'h500, 3'd4);
    step();

    // flush beats simultaneous write
    iFLUSH = 1'b1;
    wr(1'b1, 5'd9, 1'b0, 32'h99);
    step();
    iFLUSH = 1'b0;
    wr(1'b0, 5'd0, 1'b0, 32'h0);
    lk(5'd9, 1'b0, 5'd5, 1'b1);
    expect_gr("flush_r9_sys5_miss", 2'b00, 32'h0, 32'h0, 3'd0);
    step();
    lk(5'd5, 1'b0, 5'd4, 1'b0);
    expect_gr("flush_r5_r4_miss", 2'b00, 32'h0, 32'h0, 3'd0);
    step();
    wr(1'b1, 5'd9, 1'b0, 32'h55); step();
    wr(1'b0, 5'd0, 1'b0, 32'h0);
    lk(5'd9, 1'b0, 5'd9, 1'b0);
    expect_gr("r9_after_flush", 2'b11, 32'h55, 32'h55, 3'd1);
    step();

    // SPR priority
    iWB_SPR_VALID = 1'b1; iWB_SPR_DATA = 32'h1000;
    iWB_AUTO_SPR_VALID = 1'b1; iWB_AUTO_SPR_DATA = 32'h2000;
    iCUUR_SPR_DATA = 32'h3000;
    step();
    expect_all("spr_explicit_wins", 2'b11, 32'h55, 32'h55, 3'd1, 1'b1, 1'b1, 32'h1000);
    iWB_SPR_VALID = 1'b0;
    step();
    expect_all("spr_auto", 2'b11, 32'h55, 32'h55, 3'd1, 1'b1, 1'b1, 32'h2000);
    iWB_AUTO_SPR_VALID = 1'b0;
    step();
    expect_all("spr_current", 2'b11, 32'h55, 32'h55, 3'd1, 1'b1, 1'b1, 32'h3000);
    iFLUSH = 1'b1; iCUUR_SPR_DATA = 32'h3456;
    step();
    iFLUSH = 1'b0;
    expect_all("spr_through_flush", 2'b00, 32'h0, 32'h0, 3'd0, 1'b1, 1'b1, 32'h3456);
    step();

    // synchronous reset
    wr(1'b1, 5'd2, 1'b0, 32'h22); step();
    wr(1'b1, 5'd6, 1'b0, 32'h66); step();
    wr(1'b0, 5'd0, 1'b0, 32'h0);
    lk(5'd2, 1'b0, 5'd6, 1'b0);
    expect_all("loaded", 2'b11, 32'h22, 32'h66, 3'd2, 1'b1, 1'b1, 32'h3456);
    step();
    iRESET_SYNC = 1'b1;
    step();
    iRESET_SYNC = 1'b0;
    expect_all("sync_reset", 2'b00, 32'h0, 32'h0, 3'd0, 1'b1, 1'b0, 32'h0);
    step();

    // asynchronous reset mid-cycle
    wr(1'b1, 5'd2, 1'b0, 32'h22); step();
    wr(1'b1, 5'd6, 1'b0, 32'h66); step();
    wr(1'b0, 5'd0, 1'b0, 32'h0);
    expect_all("reloaded", 2'b11, 32'h22, 32'h66, 3'd2, 1'b1, 1'b1, 32'h3456);
    @(negedge iCLOCK);
    #1;
    inRESET = 1'b0;
    #1;
    expect_all("async_reset_immediate", 2'b00, 32'h0, 32'h0, 3'd0, 1'b1, 1'b0, 32'h0);
    probe = 1'b1;
    #1;
    probe = 1'b0;
    step();
    inRESET = 1'b1;
    step();
    expect_all("after_async_release", 2'b00, 32'h0, 32'h0, 3'd0, 1'b1, 1'b1, 32'h3456);
    step();

    @(negedge iCLOCK);
    #1;
    if (exp_q.size() != 0) begin
      miscompares++;
      $display("FAIL drain: got %0d pending expectations, need 0", exp_q.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
